line_kcpe_conv2d_array: RTL and testbench

Parametrised successor of the line kernel-channel PE engine. NUM_KCPE kernel-channel PEs run in lockstep. Each PE computes the MAC for NUM_KERNEL kernels over NUM_CHANNEL channels of its own pixel position, accumulated over KERNEL_SIZE taps. On the last tap each PE adds an optional incoming partial sum and emits the result. The block sits between the line/data buffer plus weight feeder upstream and the psum buffer downstream, and adds a protocol-error counter.

---
 rtl/line_kcpe_conv2d_array.sv | 92 +++++++++
 tb/tb_line_kcpe_conv2d_array.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/line_kcpe_conv2d_array.sv
// line_kcpe_conv2d_array: NUM_KCPE lockstep kernel-channel PEs accumulating KERNEL_SIZE taps with psum add and protocol-error count
module line_kcpe_conv2d_array #(
  parameter int BIT_WIDTH   = 8,
  parameter int PSUM_WIDTH  = 16,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_KERNEL  = 4,
  parameter int NUM_KCPE    = 3,
  parameter int KERNEL_SIZE = 3,
  parameter int REG_WIDTH   = 32,
  localparam int TW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_clear,
  input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KCPE-1:0]   i_data,
  input  logic                                        i_data_val,
  input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_weight,
  input  logic                                        i_weight_val,
  input  logic                                        i_psum_en,
  input  logic [PSUM_WIDTH*NUM_KERNEL*NUM_KCPE-1:0]   i_psum,
  input  logic                                        i_psum_val,
  output logic [PSUM_WIDTH*NUM_KERNEL*NUM_KCPE-1:0]   o_psum,
  output logic [NUM_KCPE-1:0]                         o_psum_val,
  output logic [TW-1:0]                               o_tap_cnt,
  output logic [REG_WIDTH-1:0]                        err_psum_val
);
  localparam int PSW = PSUM_WIDTH*NUM_KERNEL*NUM_KCPE;
  logic                        step, last, err_ev;
  logic [TW-1:0]               tap;
  logic signed [2*BIT_WIDTH-1:0] prod [NUM_KCPE][NUM_KERNEL][NUM_CHANNEL];
  logic                        s1_val, s1_first, s1_last, o_val;
  logic [PSW-1:0]              s1_psum;
  logic [PSUM_WIDTH-1:0]       acc [NUM_KCPE][NUM_KERNEL];
  logic [PSUM_WIDTH-1:0]       tot [NUM_KCPE][NUM_KERNEL];
  assign step   = i_data_val & i_weight_val & ~i_clear;
  assign last   = step & (tap == TW'(KERNEL_SIZE-1));
  assign err_ev = ~i_clear & ((i_data_val & ~i_weight_val) | (last & i_psum_en & ~i_psum_val)
                              | (i_psum_val & ~(last & i_psum_en)));
  assign o_tap_cnt  = tap;
  assign o_psum_val = {NUM_KCPE{o_val}};
  // products carry no reset; their use is gated by s1_val
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_KCPE; p++)
      for (int k = 0; k < NUM_KERNEL; k++)
        for (int c = 0; c < NUM_CHANNEL; c++)
          prod[p][k][c] <= $signed(i_data[(p*NUM_CHANNEL+c)*BIT_WIDTH +: BIT_WIDTH])
                         * $signed(i_weight[(k*NUM_CHANNEL+c)*BIT_WIDTH +: BIT_WIDTH]);
  end
  // tap 0 starts from zero so no value carries over between windows
  always_comb begin
    for (int p = 0; p < NUM_KCPE; p++)
      for (int k = 0; k < NUM_KERNEL; k++) begin
        tot[p][k] = s1_first ? '0 : acc[p][k];
        for (int c = 0; c < NUM_CHANNEL; c++)
          tot[p][k] = tot[p][k] + PSUM_WIDTH'(prod[p][k][c]);
      end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap          <= '0;
      err_psum_val <= '0;
      s1_val       <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_psum      <= '0;
      o_val        <= 1'b0;
      o_psum       <= '0;
      for (int p = 0; p < NUM_KCPE; p++)
        for (int k = 0; k < NUM_KERNEL; k++)
          acc[p][k] <= '0;
    end else begin
      tap      <= (i_clear || last) ? '0 : step ? tap + TW'(1) : tap;
      if (err_ev && !(&err_psum_val))
        err_psum_val <= err_psum_val + REG_WIDTH'(1);
      s1_val   <= step;
      s1_first <= step & (tap == '0);
      s1_last  <= last;
      s1_psum  <= (last & i_psum_en & i_psum_val) ? i_psum : '0;
      o_val    <= s1_val & s1_last & ~i_clear;
      for (int p = 0; p < NUM_KCPE; p++)
        for (int k = 0; k < NUM_KERNEL; k++) begin
          if (i_clear)
            acc[p][k] <= '0;
          else if (s1_val)
            acc[p][k] <= tot[p][k];
          if (s1_val && s1_last && !i_clear)
            o_psum[(p*NUM_KERNEL+k)*PSUM_WIDTH +: PSUM_WIDTH]
              <= tot[p][k] + s1_psum[(p*NUM_KERNEL+k)*PSUM_WIDTH +: PSUM_WIDTH];
        end
    end
  end
endmodule

// File: tb/tb_line_kcpe_conv2d_array.sv
// tb_line_kcpe_conv2d_array: directed and random steps against a window-level reference model with a result scoreboard
module tb_line_kcpe_conv2d_array;
  localparam int BW = 8, PW = 16, NC = 3, NK = 4, NP = 3, K = 3, RW = 32, TW = 2;
  localparam int OW = PW*NK*NP;
  typedef struct { logic [OW-1:0] v; int cyc; } exp_t;
  logic clk = 1'b0, rst = 1'b0, i_clear = 1'b0;
  logic [BW*NC*NP-1:0] i_data = '0;
  logic [BW*NC*NK-1:0] i_weight = '0;
  logic [OW-1:0] i_psum = '0, o_psum;
  logic i_data_val = 1'b0, i_weight_val = 1'b0, i_psum_en = 1'b0, i_psum_val = 1'b0;
  logic [NP-1:0] o_psum_val;
  logic [TW-1:0] o_tap_cnt;
  logic [RW-1:0] err_psum_val;
  logic signed [BW-1:0] d [NP][NC];
  logic signed [BW-1:0] w [NK][NC];
  logic signed [PW-1:0] ps [NP][NK];
  int m_acc [NP][NK];
  int m_tap = 0;
  longint m_err = 0;
  logic [OW-1:0] last_exp = '0;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;

  line_kcpe_conv2d_array dut (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_data(i_data), .i_data_val(i_data_val),
    .i_weight(i_weight), .i_weight_val(i_weight_val), .i_psum_en(i_psum_en), .i_psum(i_psum),
    .i_psum_val(i_psum_val), .o_psum(o_psum), .o_psum_val(o_psum_val), .o_tap_cnt(o_tap_cnt),
    .err_psum_val(err_psum_val));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every output pulse must match the oldest expected window result at its cycle
  always @(negedge clk) if (rst) begin
    if (o_psum_val != '0) begin
      exp_t e;
      chk("val_bits_equal", OW'(o_psum_val), OW'({NP{1'b1}}));
      if (q.size() == 0) chk("unexpected_valid", OW'(1), OW'(0));
      else begin
        e = q.pop_front();
        chk("latency", OW'(cyc), OW'(e.cyc));
        chk("psum", o_psum, e.v);
        last_exp = e.v;
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t e = q.pop_front();
      chk("missed_valid", OW'(0), OW'(1));
    end
  end

  task automatic fill(input int dv, input int wv, input int pv);
    for (int p = 0; p < NP; p++) for (int c = 0; c < NC; c++) d[p][c] = BW'(dv);
    for (int k = 0; k < NK; k++) for (int c = 0; c < NC; c++) w[k][c] = BW'(wv);
    for (int p = 0; p < NP; p++) for (int k = 0; k < NK; k++) ps[p][k] = PW'(pv);
  endtask

  task automatic randomize_vals();
    for (int p = 0; p < NP; p++) for (int c = 0; c < NC; c++) d[p][c] = BW'($urandom);
    for (int k = 0; k < NK; k++) for (int c = 0; c < NC; c++) w[k][c] = BW'($urandom);
    for (int p = 0; p < NP; p++) for (int k = 0; k < NK; k++) ps[p][k] = PW'($urandom);
  endtask

  // drive one cycle and advance the reference model for the edge that will sample it
  task automatic apply(input bit dv, input bit wv, input bit pen, input bit pv, input bit clr);
    int n;
    bit st, lst;
    @(posedge clk); #1;
    n = cyc;
    for (int p = 0; p < NP; p++) for (int c = 0; c < NC; c++) i_data[(p*NC+c)*BW +: BW] = d[p][c];
    for (int k = 0; k < NK; k++) for (int c = 0; c < NC; c++) i_weight[(k*NC+c)*BW +: BW] = w[k][c];
    for (int p = 0; p < NP; p++) for (int k = 0; k < NK; k++) i_psum[(p*NK+k)*PW +: PW] = ps[p][k];
    i_data_val = dv; i_weight_val = wv; i_psum_en = pen; i_psum_val = pv; i_clear = clr;
    if (clr) begin
      exp_t keep[$];
      m_tap = 0;
      foreach (q[i]) if (q[i].cyc <= n) keep.push_back(q[i]);
      q = keep;
    end else begin
      st  = dv && wv;
      lst = st && (m_tap == K-1);
      if (((dv && !wv) || (lst && pen && !pv) || (pv && !(lst && pen))) && m_err < 64'hFFFF_FFFF)
        m_err++;
      if (st) begin
        for (int p = 0; p < NP; p++) for (int k = 0; k < NK; k++) begin
          int s = 0;
          for (int c = 0; c < NC; c++) s += int'(d[p][c]) * int'(w[k][c]);
          m_acc[p][k] = (m_tap == 0) ? s : m_acc[p][k] + s;
          if (lst && pen && pv) m_acc[p][k] += int'(ps[p][k]);
        end
        if (lst) begin
          exp_t e;
          e.cyc = n + 2;
          for (int p = 0; p < NP; p++) for (int k = 0; k < NK; k++) begin
            int a = m_acc[p][k];
            e.v[(p*NK+k)*PW +: PW] = a[PW-1:0];
          end
          q.push_back(e);
        end
        m_tap = lst ? 0 : m_tap + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0);
  endtask

  task automatic steps(input int n, input bit pen_last, input bit pv_last);
    for (int i = 0; i < n; i++) apply(1, 1, pen_last && i == n-1, pv_last && i == n-1, 0);
  endtask

  task automatic check_status(input string tag);
    idle(3);
    @(negedge clk);
    chk({tag, "_tap"}, OW'(o_tap_cnt), OW'(m_tap));
    chk({tag, "_err"}, OW'(err_psum_val), OW'(m_err));
    chk({tag, "_hold"}, o_psum, last_exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    i_data_val = 0; i_weight_val = 0; i_psum_en = 0; i_psum_val = 0; i_clear = 0;
    q.delete();
    m_tap = 0; m_err = 0; last_exp = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    fill(0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_psum", o_psum, '0);
    chk("reset_val", OW'(o_psum_val), '0);
    chk("reset_tap", OW'(o_tap_cnt), '0);
    chk("reset_err", OW'(err_psum_val), '0);
    fill(1, 2, 0);  steps(3, 0, 0); check_status("basic18");
    fill(1, 2, 100); steps(3, 1, 1); check_status("psum118");
    fill(-128, -128, 0); steps(3, 0, 0); check_status("signed_wrap");
    fill(1, 0, 0);
    for (int c = 0; c < NC; c++) w[0][c] = 1;
    steps(6, 0, 0); check_status("back_to_back");
    fill(1, 2, 55);
    apply(1, 0, 0, 0, 0); check_status("err_a");
    steps(3, 1, 0); check_status("err_b");
    apply(0, 0, 0, 1, 0); check_status("err_c");
    apply(0, 1, 0, 0, 0); check_status("weight_only");
    steps(2, 0, 0); do_reset(); steps(3, 0, 0); check_status("reset_mid");
    steps(2, 0, 0); apply(1, 1, 0, 0, 1); steps(3, 0, 0); check_status("clear_mid");
    for (int i = 0; i < 400; i++) begin
      randomize_vals();
      apply($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
    end
    check_status("random");
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never seen, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end
endmodule
